// File: rtl/fifo_write_ctrl.sv
// Write-side controller for the single-clock FIFO: pointer, flags, registered memory port.
// Optional FIFO_WRITE_CTRL_GRAY_EN adds a registered Gray-coded write pointer output.
module fifo_write_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH:0]   read_ptr,
    input  logic                  clear_overflow,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [ADDR_WIDTH:0]   write_ptr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
`ifdef FIFO_WRITE_CTRL_GRAY_EN
    ,
    output logic [ADDR_WIDTH:0]   write_ptr_gray
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic                accept;
    logic [ADDR_WIDTH:0] write_ptr_next;

    // Flags come from pre-edge pointers, so a write at full is rejected even alongside a read
    assign full = (write_ptr[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]) &&
                  (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]);
    assign level          = write_ptr - read_ptr;
    assign almost_full    = (level >= AFULL_LVL);
    assign accept         = write_en && !full;
    assign write_ptr_next = write_ptr + PTR_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ptr <= '0;
        end else if (accept) begin
            write_ptr <= write_ptr_next;
        end
    end

    // Address and data hold their last accepted values between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_write_en   <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_en <= accept;
            if (accept) begin
                mem_write_addr <= write_ptr[ADDR_WIDTH-1:0];
                mem_write_data <= write_data;
            end
        end
    end

    // Set has priority over clear when both happen in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (write_en && full) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef FIFO_WRITE_CTRL_GRAY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ptr_gray <= '0;
        end else if (accept) begin
            write_ptr_gray <= write_ptr_next ^ (write_ptr_next >> 1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with a scoreboard of expected memory writes.
// Define FIFO_WRITE_CTRL_GRAY_EN to also check the Gray pointer.
module tb_fifo_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en;
    logic [7:0] write_data;
    logic [5:0] read_ptr;
    logic       clear_overflow;
    logic       mem_write_en;
    logic [4:0] mem_write_addr;
    logic [7:0] mem_write_data;
    logic [5:0] write_ptr;
    logic [5:0] level;
    logic       full;
    logic       almost_full;
    logic       overflow;
`ifdef FIFO_WRITE_CTRL_GRAY_EN
    logic [5:0] write_ptr_gray;
    logic [5:0] prev_gray;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];
    logic [5:0]  mwp, mrp;
    logic        movf;
    logic [4:0]  last_addr;
    logic [7:0]  last_data;
    logic        wrap_seen;

    fifo_write_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .AFULL_THRESH(28)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write_en(write_en),
        .write_data(write_data),
        .read_ptr(read_ptr),
        .clear_overflow(clear_overflow),
        .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .write_ptr(write_ptr),
        .level(level),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow)
`ifdef FIFO_WRITE_CTRL_GRAY_EN
        ,
        .write_ptr_gray(write_ptr_gray)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mwp       = '0;
        mrp       = '0;
        movf      = 1'b0;
        last_addr = '0;
        last_data = '0;
        exp_q.delete();
`ifdef FIFO_WRITE_CTRL_GRAY_EN
        prev_gray = '0;
`endif
    endtask

    // One clock: drive inputs, predict, then check everything after the edge
    task automatic tick(input logic we, input logic [7:0] d,
                        input logic rd, input logic clr);
        logic       acc;
        logic [5:0] lvl;
        logic [5:0] old_wp;
        logic [12:0] e;
        write_en       = we;
        write_data     = d;
        clear_overflow = clr;
        lvl = mwp - mrp;
        acc = we && (lvl != 6'd32);
        if (acc) exp_q.push_back({mwp[4:0], d});
        old_wp = write_ptr;
        @(posedge clk);
        #1;
        if (acc) mwp = mwp + 6'd1;
        if (we && !acc) movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (rd) begin
            mrp      = mrp + 6'd1;
            read_ptr = mrp;
        end
        write_en       = 1'b0;
        clear_overflow = 1'b0;
        #1;
        lvl = mwp - mrp;
        if (old_wp == 6'd63 && write_ptr == 6'd0) wrap_seen = 1'b1;
        chk("mem_write_en", mem_write_en, acc);
        if (mem_write_en) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mem_write_addr", mem_write_addr, e[12:8]);
                chk("mem_write_data", mem_write_data, e[7:0]);
                last_addr = e[12:8];
                last_data = e[7:0];
            end
        end else begin
            chk("addr_hold", mem_write_addr, last_addr);
            chk("data_hold", mem_write_data, last_data);
        end
        chk("write_ptr", write_ptr, mwp);
        chk("level", level, lvl);
        chk("full", full, lvl == 6'd32);
        chk("almost_full", almost_full, lvl >= 6'd28);
        chk("overflow", overflow, movf);
`ifdef FIFO_WRITE_CTRL_GRAY_EN
        chk("gray_value", write_ptr_gray, mwp ^ (mwp >> 1));
        if (acc) chk("gray_onebit", $countones(write_ptr_gray ^ prev_gray), 1);
        prev_gray = write_ptr_gray;
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_write_ptr"}, write_ptr, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_almost_full"}, almost_full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_mem_write_en"}, mem_write_en, 0);
        chk({tag, "_mem_write_addr"}, mem_write_addr, 0);
        chk({tag, "_mem_write_data"}, mem_write_data, 0);
`ifdef FIFO_WRITE_CTRL_GRAY_EN
        chk({tag, "_gray"}, write_ptr_gray, 0);
`endif
    endtask

    initial begin
        rst            = 1'b1;
        write_en       = 1'b0;
        write_data     = '0;
        read_ptr       = '0;
        clear_overflow = 1'b0;
        wrap_seen      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        #1;

        // Fill all 32 entries
        for (int i = 0; i < 32; i++) tick(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_wp", write_ptr, 6'b100000);

        // Rejected writes at full, then clear
        for (int i = 0; i < 3; i++) tick(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 0);

        // Set and clear together: set wins
        tick(1'b1, 8'hDD, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);

        // Level 31, then read and write on the same edge
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("rw_level", level, 31);
        chk("rw_full", full, 0);

        // Drain to 2, then stream 40 words with read trailing by 2
        for (int i = 0; i < 29; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_level", level, 2);

        // Drain, build level 10, reset mid-burst
        for (int i = 0; i < 2; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre_rst_level", level, 10);
        write_en   = 1'b1;
        write_data = 8'h77;
        #2;
        rst      = 1'b1;
        read_ptr = '0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        write_en = 1'b0;
        rst      = 1'b0;
        model_reset();
        #1;
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("post_rst_addr", mem_write_addr, 0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Parametrised write-side controller for the single-clock FIFO. It accepts producer writes, owns the binary write pointer, and derives full, almost-full and fill level from the read pointer. It drives the dual-port memory through a one-stage registered write port and latches a sticky overflow flag on rejected writes. It sits between the producer and the FIFO memory, alongside the read-side controller in the same clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, width of write data.
- ADDR_WIDTH, 5, memory address width; depth = 2^ADDR_WIDTH.
- AFULL_THRESH, 28, level at or above which almost_full asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  producer write request.
- write_data  in  DATA_WIDTH  producer data.
- read_ptr  in  ADDR_WIDTH+1  binary read pointer from the read controller, same clock, with wrap bit.
- clear_overflow  in  1  clears the sticky overflow flag.
- mem_write_en  out  1  registered memory write strobe.
- mem_write_addr  out  ADDR_WIDTH  registered memory address.
- mem_write_data  out  DATA_WIDTH  registered memory data.
- write_ptr  out  ADDR_WIDTH+1  binary write pointer, with wrap bit.
- level  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH.
- full  out  1  FIFO full.
- almost_full  out  1  level >= AFULL_THRESH.
- overflow  out  1  sticky: a write was attempted while full.

## Operation
- accept = write_en && !full. This is evaluated combinationally from current write_ptr and read_ptr.
- On accept, write_ptr <= write_ptr + 1 (mod 2^(ADDR_WIDTH+1)). The wrap bit toggles when the low bits roll over from 2^ADDR_WIDTH-1 to 0.
- Memory stage, registered:
  - mem_write_en <= accept.
  - mem_write_addr <= write_ptr[ADDR_WIDTH-1:0], the pre-increment value.
  - mem_write_data <= write_data.
  - When accept is 0, mem_write_addr and mem_write_data hold their previous values.
- level = write_ptr - read_ptr, modulo 2^(ADDR_WIDTH+1). This is combinational.
- full = (write_ptr[MSB] != read_ptr[MSB]) && (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]). This is combinational, equivalent to level == 2^ADDR_WIDTH.
- almost_full = (level >= AFULL_THRESH). This is combinational.
- Overflow flag:
  - Set on the clock edge after write_en && full.
  - Cleared on the clock edge after clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- A write that is rejected while full does not move write_ptr and does not assert mem_write_en.
- A simultaneous read (read_ptr advancing) and write in the same cycle: level is unchanged the following cycle. full is based on the pre-edge pointers, so a write in a cycle where full=1 is rejected even if a read also occurs.
- Reset (asynchronous, any time including mid-burst) forces write_ptr=0, mem_write_en=0, mem_write_addr=0, mem_write_data=0 and overflow=0 immediately. level, full and almost_full then follow the pointers. The read side is reset by the same rst.

## Timing
- Write acceptance to write_ptr update: 1 cycle. full, level and almost_full reflect the new pointer in that same following cycle.
- Write acceptance to memory write: mem_write_* are valid 1 cycle after the accepting edge; the memory samples them on the next edge.
- Producer may hold write_en high continuously; one word is accepted per cycle while !full.
- read_ptr must be registered in clk; no combinational path exists from write_en to read_ptr.
- Reset values:
  - write_ptr=0, level=0, full=0, almost_full=0, overflow=0.
  - mem_write_en=0, mem_write_addr=0, mem_write_data=0.
  - almost_full is 0 after reset because level 0 < AFULL_THRESH ≥ 1.

## Configuration
- Macro FIFO_WRITE_CTRL_GRAY_EN.
- Defined:
  - Adds output write_ptr_gray (ADDR_WIDTH+1), a registered Gray code of the post-increment write_ptr (write_ptr ^ (write_ptr >> 1)), updated on the same edge as write_ptr.
  - Reset value is 0. Exactly one bit changes per accepted write.
  - Intended for a future async read side.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset then 32 consecutive writes (ADDR_WIDTH=5), read_ptr=0:
  - mem_write_addr 0..31 in order, level reaches 32.
  - full=1 after the 32nd accept; almost_full=1 from level 28.
  - write_ptr=6'b100000.
- At full, hold write_en for 3 cycles, then pulse clear_overflow:
  - write_ptr and mem_write_en stay unchanged; overflow=1 from the cycle after the first attempt.
  - overflow=0 one cycle after the clear.
- Simultaneous set and clear of overflow in the same cycle -> overflow=1.
- Fill to 31, then advance read_ptr by 1 and write in the same cycle -> write accepted, level stays 31, full=0.
- Wrap: write and read 40 words with read_ptr trailing by 2:
  - write_ptr wraps 6'b111111 -> 6'b000000.
  - level stays 2, full never asserts, addresses wrap 31 -> 0.
- Assert rst mid-burst (level=10) -> all outputs 0 asynchronously; first write after release goes to address 0.
- With FIFO_WRITE_CTRL_GRAY_EN defined, check that write_ptr_gray changes by exactly one bit per accepted write across the full wrap.
